lcd_bus_writer: RTL and testbench
=================================

# lcd_bus_writer

Parametrised HD44780-style LCD bus write engine. It accepts one command or data byte per ready/valid handshake and drives LCD_D/LCD_RS/LCD_E with programmable setup, enable-pulse and hold times. In 4-bit mode it splits the byte into two nibbles, high nibble first, and it then waits a per-command settle delay before signalling completion. It sits between the LCD init/print sequencer and the LCD pins, and supersedes the fixed 5-bit single-strobe transfer unit.

## Interface
- CLK_FREQ_HZ, 50000000, clock frequency; one microsecond is CLK_FREQ_HZ/1000000 cycles (TUS).
- BUS_WIDTH, 4, LCD data bus width; legal values are 4 and 8.
- SETUP_US, 1, data/RS valid before the E rise; T_SETUP = SETUP_US*TUS cycles.
- E_PULSE_US, 3, E high time; T_E = E_PULSE_US*TUS cycles.
- HOLD_US, 1, data/RS held after the E fall; T_HOLD = HOLD_US*TUS cycles.
- DELAY_W, 21, width of the per-command delay field.

Each of T_SETUP, T_E and T_HOLD must be at least 1. Elaboration fails on an illegal BUS_WIDTH or on any zero-length phase.

- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; a command is accepted at the edge where cmd_valid and cmd_ready are both 1.
- cmd_data  in  8  byte to write.
- cmd_rs  in  1  value for LCD_RS (0 = instruction, 1 = data).
- cmd_nibble_only  in  1  4-bit mode only: send cmd_data[7:4] as a single beat (used for init). Ignored when BUS_WIDTH=8.
- cmd_delay  in  DELAY_W  settle cycles after the last hold phase; 0 is legal.
- LCD_D  out  BUS_WIDTH  LCD data bus.
- LCD_RS  out  1  register select.
- LCD_E  out  1  enable strobe.
- done  out  1  one-cycle pulse when the command completes.

## Operation
- All of cmd_data, cmd_rs, cmd_nibble_only and cmd_delay are captured at the accept edge. Inputs are ignored at all other times.
- Beat count:
  - 1 when BUS_WIDTH=8.
  - 1 when BUS_WIDTH=4 and cmd_nibble_only=1.
  - 2 otherwise.
- Beat data:
  - 8-bit mode: the full byte.
  - 4-bit mode: beat 0 is [7:4], beat 1 is [3:0].
- States and transitions:
  - IDLE: cmd_ready=1; all LCD outputs 0. On accept, go to SETUP with beat 0 and clear the timer.
  - SETUP: LCD_D=beat data, LCD_RS=captured rs, LCD_E=0. Lasts exactly T_SETUP cycles, then E_HIGH.
  - E_HIGH: as SETUP but LCD_E=1. Lasts exactly T_E cycles, then HOLD.
  - HOLD: as SETUP (LCD_E=0, data and RS still driven). Lasts exactly T_HOLD cycles. Then:
    - SETUP with the next beat if one remains;
    - else DELAY if the captured delay is nonzero;
    - else DONE.
  - DELAY: LCD_D=0, LCD_RS=0, LCD_E=0. Lasts exactly the captured delay cycles, then DONE.
  - DONE: done=1 for one cycle, outputs 0, then IDLE.
- A single timer counter, sized to the largest of T_SETUP, T_E, T_HOLD and 2^DELAY_W-1, is cleared on every state change.
- cmd_ready is 1 only in IDLE and is forced to 0 while RST is asserted. There is no back-to-back accept during DONE.
- Outputs are registered. LCD_E shows no glitch at phase boundaries.

## Timing
- Reset: state=IDLE, timer=0 and captured registers=0, applied asynchronously. LCD_D=0, LCD_RS=0, LCD_E=0, done=0 and cmd_ready=0 during reset; cmd_ready=1 from the first cycle after release.
- Reset mid-transfer: LCD_E drops to 0 immediately, with no done pulse. The aborted command is lost.
- Accept at edge k: SETUP is visible from cycle k+1.
- Busy length per beat is T_SETUP+T_E+T_HOLD cycles.
- done is asserted at cycle k+1+beats*(T_SETUP+T_E+T_HOLD)+delay. cmd_ready returns one cycle later.
- In 4-bit two-beat mode, the second beat's SETUP follows the first beat's HOLD directly, with no gap.
- cmd_delay at its maximum of 2^DELAY_W-1 must count fully without wrap.

## Test plan
All scenarios use CLK_FREQ_HZ=4000000 (TUS=4), giving T_SETUP=4, T_E=12, T_HOLD=4 and 20 cycles per beat.

- 8-bit, data 0xA5, rs=1, delay=0:
  - LCD_D=0xA5 and LCD_RS=1 for 20 cycles.
  - LCD_E high for exactly 12 cycles, starting 4 cycles after SETUP begins.
  - done 21 cycles after accept; cmd_ready one cycle later.
- 4-bit, data 0x3C, rs=0, delay=10:
  - Beat 0x3 for 20 cycles, then 0xC for 20 cycles.
  - Two E pulses, each 12 cycles, with rising edges 20 cycles apart.
  - Outputs 0 for 10 cycles, then done at accept+51.
- 4-bit, nibble_only=1, data 0x30:
  - Single beat 0x3 and a single E pulse.
  - done at accept+21.
- Back-to-back: cmd_valid held high with two commands queued.
  - Second accept occurs exactly 1 cycle after the done pulse.
  - cmd_data changes while busy do not alter LCD_D.
- Reset asserted during E_HIGH:
  - LCD_E, LCD_D and cmd_ready go to 0 immediately; no done pulse.
  - cmd_ready=1 on the first cycle after release; a new command completes normally.
- DELAY_W=4, delay=15:
  - DELAY phase lasts exactly 15 cycles with no wrap.
  - done asserted exactly once.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// HD44780-style LCD bus write engine: one byte per handshake, timed setup/E/hold
// phases, optional 4-bit nibble split and a per-command settle delay.
module lcd_bus_writer #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BUS_WIDTH   = 4,
    parameter int unsigned SETUP_US    = 1,
    parameter int unsigned E_PULSE_US  = 3,
    parameter int unsigned HOLD_US     = 1,
    parameter int unsigned DELAY_W     = 21
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_data,
    input  logic                 cmd_rs,
    input  logic                 cmd_nibble_only,
    input  logic [DELAY_W-1:0]   cmd_delay,
    output logic [BUS_WIDTH-1:0] LCD_D,
    output logic                 LCD_RS,
    output logic                 LCD_E,
    output logic                 done
);

    localparam int unsigned TUS     = CLK_FREQ_HZ / 1000000;
    localparam int unsigned T_SETUP = SETUP_US * TUS;
    localparam int unsigned T_E     = E_PULSE_US * TUS;
    localparam int unsigned T_HOLD  = HOLD_US * TUS;
    localparam int unsigned T_MAX1  = (T_SETUP > T_E) ? T_SETUP : T_E;
    localparam int unsigned T_MAX   = (T_MAX1 > T_HOLD) ? T_MAX1 : T_HOLD;
    localparam int unsigned T_BITS  = $clog2(T_MAX + 1);
    localparam int unsigned TW      = (T_BITS > DELAY_W) ? T_BITS : DELAY_W;

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("lcd_bus_writer: BUS_WIDTH must be 4 or 8");
    end
    if (T_SETUP == 0 || T_E == 0 || T_HOLD == 0) begin : g_bad_phase
        $error("lcd_bus_writer: every bus phase must be at least one cycle");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_DELAY,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic               beat, beat_n;
    logic [7:0]         data_q, data_n;
    logic               rs_q, rs_n;
    logic               two_q, two_n;
    logic [DELAY_W-1:0] delay_q, delay_n;

    logic [BUS_WIDTH-1:0] lcd_d_n;
    logic                 lcd_rs_n, lcd_e_n, done_n, ready_n;
    logic [7:0]           beat_sel;

    // State, timer and captured command
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            timer   <= '0;
            beat    <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            two_q   <= 1'b0;
            delay_q <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            beat    <= beat_n;
            data_q  <= data_n;
            rs_q    <= rs_n;
            two_q   <= two_n;
            delay_q <= delay_n;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LCD_D     <= '0;
            LCD_RS    <= 1'b0;
            LCD_E     <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            LCD_D     <= lcd_d_n;
            LCD_RS    <= lcd_rs_n;
            LCD_E     <= lcd_e_n;
            done      <= done_n;
            cmd_ready <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer + TW'(1);
        beat_n   = beat;
        data_n   = data_q;
        rs_n     = rs_q;
        two_n    = two_q;
        delay_n  = delay_q;
        lcd_d_n  = '0;
        lcd_rs_n = 1'b0;
        lcd_e_n  = 1'b0;
        done_n   = 1'b0;
        ready_n  = 1'b0;
        beat_sel = 8'h00;

        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (cmd_valid && cmd_ready) begin
                    state_n = S_SETUP;
                    beat_n  = 1'b0;
                    data_n  = cmd_data;
                    rs_n    = cmd_rs;
                    two_n   = (BUS_WIDTH == 4) && !cmd_nibble_only;
                    delay_n = cmd_delay;
                end
            end
            S_SETUP: begin
                if (timer == TW'(T_SETUP - 1)) begin
                    state_n = S_E_HIGH;
                    timer_n = '0;
                end
            end
            S_E_HIGH: begin
                if (timer == TW'(T_E - 1)) begin
                    state_n = S_HOLD;
                    timer_n = '0;
                end
            end
            S_HOLD: begin
                if (timer == TW'(T_HOLD - 1)) begin
                    timer_n = '0;
                    if (two_q && !beat) begin
                        state_n = S_SETUP;
                        beat_n  = 1'b1;
                    end else if (delay_q != '0) begin
                        state_n = S_DELAY;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DELAY: begin
                // timer is at least DELAY_W wide, so the maximum delay counts without wrap
                if (timer == TW'(delay_q - DELAY_W'(1))) begin
                    state_n = S_DONE;
                    timer_n = '0;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase

        if (BUS_WIDTH == 8) begin
            beat_sel = data_n;
        end else if (beat_n) begin
            beat_sel = {4'h0, data_n[3:0]};
        end else begin
            beat_sel = {4'h0, data_n[7:4]};
        end

        case (state_n)
            S_SETUP, S_E_HIGH, S_HOLD: begin
                lcd_d_n  = BUS_WIDTH'(beat_sel);
                lcd_rs_n = rs_n;
                lcd_e_n  = (state_n == S_E_HIGH);
            end
            S_DONE:  done_n  = 1'b1;
            S_IDLE:  ready_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: an 8-bit instance and a 4-bit instance
// (DELAY_W=4), both at TUS=4, checked cycle by cycle against a timeline model.
module tb_lcd_bus_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v8 = 1'b0, rs8 = 1'b0, nib8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic [20:0] del8 = '0;
    logic       rdy8, lrs8, le8, done8;
    logic [7:0] ld8;

    logic       v4 = 1'b0, rs4 = 1'b0, nib4 = 1'b0;
    logic [7:0] d4 = 8'h00;
    logic [3:0] del4 = '0;
    logic       rdy4, lrs4, le4, done4;
    logic [3:0] ld4;

    int checks = 0;
    int errors = 0;

    lcd_bus_writer #(.CLK_FREQ_HZ(4000000), .BUS_WIDTH(8), .DELAY_W(21)) u8 (
        .CLK(clk), .RST(rst), .cmd_valid(v8), .cmd_ready(rdy8), .cmd_data(d8),
        .cmd_rs(rs8), .cmd_nibble_only(nib8), .cmd_delay(del8),
        .LCD_D(ld8), .LCD_RS(lrs8), .LCD_E(le8), .done(done8));

    lcd_bus_writer #(.CLK_FREQ_HZ(4000000), .BUS_WIDTH(4), .DELAY_W(4)) u4 (
        .CLK(clk), .RST(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_data(d4),
        .cmd_rs(rs4), .cmd_nibble_only(nib4), .cmd_delay(del4),
        .LCD_D(ld4), .LCD_RS(lrs4), .LCD_E(le4), .done(done4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {LCD_D (zero-extended to 8), LCD_RS, LCD_E, done, cmd_ready}
    function automatic logic [11:0] obs(input int sel);
        if (sel == 0) return {ld8, lrs8, le8, done8, rdy8};
        return {4'h0, ld4, lrs4, le4, done4, rdy4};
    endfunction

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic rs,
                         input logic nib, input int del);
        if (sel == 0) begin
            v8 = v; d8 = d; rs8 = rs; nib8 = nib; del8 = 21'(del);
        end else begin
            v4 = v; d4 = d; rs4 = rs; nib4 = nib; del4 = 4'(del);
        end
    endtask

    // One full command. Unless pre is set, waits for ready and presents it.
    // After accept, either queues the next command (keep) or drops valid and
    // scribbles on the inputs so captured values are what the pins must show.
    task automatic xfer(input int sel, input logic [7:0] data, input logic rs, input logic nib,
                        input int del, input bit pre, input bit keep,
                        input logic [7:0] ndata, input logic nrs, input logic nnib, input int ndel);
        int beats, total, last, b, p, ed;
        logic [11:0] e;
        if (!pre) begin
            int w = 0;
            while (obs(sel)[0] !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            if (w == 100) chk($sformatf("u%0d ready_timeout", sel), obs(sel), 12'h001);
            drive(sel, 1'b1, data, rs, nib, del);
        end
        tick();
        if (keep) drive(sel, 1'b1, ndata, nrs, nnib, ndel);
        else      drive(sel, 1'b0, ~data, ~rs, ~nib, 0);
        beats = (sel == 0) ? 1 : (nib ? 1 : 2);
        total = beats * 20;
        last  = total + del + 2;
        for (int n = 1; n <= last; n++) begin
            if (n <= total) begin
                b  = (n - 1) / 20;
                p  = (n - 1) % 20;
                ed = (sel == 0) ? int'(data) : ((b == 0) ? int'(data >> 4) : int'(data & 8'h0F));
                e  = {8'(ed), rs, (p >= 4 && p < 16), 1'b0, 1'b0};
            end else if (n <= total + del) begin
                e = 12'h000;
            end else if (n == total + del + 1) begin
                e = 12'h002;
            end else begin
                e = 12'h001;
            end
            chk($sformatf("u%0d d=%h n=%0d", sel, data, n), obs(sel), e);
            if (n < last) tick();
        end
    endtask

    initial begin
        // reset state, then ready on the first cycle after release
        #2;
        chk("u8 in_reset", obs(0), 12'h000);
        chk("u4 in_reset", obs(1), 12'h000);
        tick();
        chk("u8 in_reset_clk", obs(0), 12'h000);
        #2 rst = 1'b0;
        tick();
        chk("u8 ready_after_reset", obs(0), 12'h001);
        chk("u4 ready_after_reset", obs(1), 12'h001);

        // 8-bit A5 rs=1 no delay
        xfer(0, 8'hA5, 1'b1, 1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b0, 0);
        // 4-bit 3C rs=0 delay 10
        xfer(1, 8'h3C, 1'b0, 1'b0, 10, 0, 0, 8'h00, 1'b0, 1'b0, 0);
        // 4-bit nibble-only init write
        xfer(1, 8'h30, 1'b0, 1'b1, 0, 0, 0, 8'h00, 1'b0, 1'b0, 0);
        // 4-bit with the maximum 4-bit delay of 15
        xfer(1, 8'hE7, 1'b1, 1'b0, 15, 0, 0, 8'h00, 1'b0, 1'b0, 0);
        // nibble_only is ignored in 8-bit mode
        xfer(0, 8'h5A, 1'b0, 1'b1, 0, 0, 0, 8'h00, 1'b0, 1'b0, 0);
        // back-to-back with valid held high; second accept right after done
        xfer(0, 8'h12, 1'b0, 1'b0, 3, 0, 1, 8'h34, 1'b1, 1'b0, 0);
        xfer(0, 8'h34, 1'b1, 1'b0, 0, 1, 0, 8'h00, 1'b0, 1'b0, 0);

        // reset in E_HIGH of a two-beat 4-bit command
        drive(1, 1'b1, 8'h96, 1'b1, 1'b0, 5);
        tick();
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("u4 pre_abort_e_high", obs(1), {8'h09, 1'b1, 1'b1, 1'b0, 1'b0});
        #2 rst = 1'b1;
        #1;
        chk("u4 abort_immediate", obs(1), 12'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("u4 abort_hold c%0d", i), obs(1), 12'h000);
        end
        #2 rst = 1'b0;
        tick();
        chk("u4 ready_after_abort", obs(1), 12'h001);
        tick();
        chk("u4 no_done_after_abort", obs(1), 12'h001);
        xfer(1, 8'h4B, 1'b1, 1'b0, 2, 0, 0, 8'h00, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
